mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multi-cycle MUL/DIV engine in EX, downstream of ALU_Control. It consumes ALU_Control's
//  valid/mode (valid=1 on MUL or DIV decode; mode 0=MUL, 1=DIV) and the operands.
//  It returns a 32-bit result and a stall that freezes the pipeline until the result is ready.
//  MUL = low DATA_W bits of product (RV32M MUL); DIV = signed quotient (RV32M DIV).
// PARAMETERS
//  DATA_W   32   operand/result width
//  CNT_W    $clog2(DATA_W)   iteration counter width (derived, not overridden)
// PORTS
//  clk      in   1        single clock, all state on rising edge
//  rst_n    in   1        asynchronous active-low reset
//  valid    in   1        start request from ALU_Control (MUL/DIV decoded)
//  mode     in   1        0 = MUL, 1 = DIV; sampled with valid
//  in_A     in   DATA_W   rs1 operand (multiplicand / dividend)
//  in_B     in   DATA_W   rs2 operand (multiplier / divisor)
//  stall    out  1        hold pipeline; combinational from state and valid
//  done     out  1        one-cycle pulse; result valid this cycle
//  result   out  DATA_W   registered result; holds until next completion
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, done=0, result=0, internal regs=0; stall driven only by valid.
//  States: IDLE -> MUL|DIV -> OUT -> IDLE. Encoding 2 bits.
//  IDLE: valid=1 at edge T -> capture operands and mode, cnt=0, go to MUL (mode 0) or DIV (mode 1).
//  MUL: shift-add, one multiplier bit per cycle into 2*DATA_W accumulator, unsigned (low bits are sign-agnostic).
//  DIV: restoring division on |in_A|, |in_B|, one quotient bit per cycle, DATA_W+1-bit partial remainder.
//  MUL/DIV: cnt increments each cycle; on cycle with cnt==DATA_W-1 go to OUT and register result.
//  Latency fixed: compute occupies T+1..T+DATA_W; OUT (done=1) is cycle T+DATA_W+1 (33 for 32).
//  DIV sign fix: quotient negated iff in_A[MSB]^in_B[MSB].
//  DIV special cases (override, same latency): in_B==0 -> result all ones (-1);
//    in_A==0x8000_0000 & in_B==-1 -> result 0x8000_0000 (no trap).
//  stall = (state==IDLE & valid) | state==MUL | state==DIV. stall=0 in OUT so the
//    instruction advances on the OUT edge carrying result.
//  valid ignored in MUL, DIV and OUT (it is the same instruction still held). No re-trigger from OUT.
//    A new start is only accepted in IDLE, so back-to-back ops have one IDLE cycle between them.
//  mode/in_A/in_B changes after capture have no effect.
//  done: high exactly one cycle (OUT), 0 otherwise. result changes only on OUT entry.
//  Reset mid-operation: abort immediately, no done pulse, result cleared to 0.
// STRUCTURE
//  Shared package (riscv_pkg): ALUSignal codes (ADD..DIV incl. MUL=4'b1010, DIV=4'b1011),
//    MD_MODE_MUL/MD_MODE_DIV constants, mul_div_unit state enum.
//  One sub-module: md_sign_abs (combinational |x| plus sign bit, DATA_W generic),
//    used for both DIV operands and quotient negation. Everything else lives in this module.
// TESTING
//  MUL 7 x 6: valid pulse, mode=0 -> stall high 33 cycles from request, done at T+33, result=42.
//  MUL 0xFFFF_FFFF x 0xFFFF_FFFF (-1 x -1) -> result=0x0000_0001; 0x8000_0000 x 2 -> 0x0000_0000.
//  DIV -7/2 -> 0xFFFF_FFFD (-3); 7/-2 -> -3; 100/7 -> 14; each done at T+33.
//  DIV by 0: 5/0 -> 0xFFFF_FFFF; -5/0 -> 0xFFFF_FFFF. 0x8000_0000/-1 -> 0x8000_0000.
//  valid held high through OUT: exactly one done, no second start.
//    valid in next IDLE cycle starts new op (back-to-back MUL then DIV, both correct).
//  rst_n low at cycle T+10 of a DIV: state IDLE asynchronously, no done ever,
//    result=0; a fresh op after release completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared decode codes, mul/div mode constants and mul_div_unit state encoding
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_MUL  = 4'b1010,
        ALU_DIV  = 4'b1011
    } alu_signal_e;

    localparam logic MD_MODE_MUL = 1'b0;
    localparam logic MD_MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_OUT  = 2'b11
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/response bundle between ALU_Control/EX and the mul/div engine
interface mul_div_unit_if #(parameter int DATA_W = 32);
    logic              valid;
    logic              mode;
    logic [DATA_W-1:0] in_A;
    logic [DATA_W-1:0] in_B;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (output valid, mode, in_A, in_B, input stall, done, result);
    modport slave  (input valid, mode, in_A, in_B, output stall, done, result);
endinterface

// File: rtl/md_sign_abs.sv
// rtl/md_sign_abs.sv - conditional two's-complement negate plus sign bit of the input
// With neg tied to the input MSB this yields |x| (as an unsigned magnitude).
module md_sign_abs #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] x,
    input  logic              neg,
    output logic [DATA_W-1:0] y,
    output logic              sign
);
    assign sign = x[DATA_W-1];
    assign y    = neg ? ((~x) + {{(DATA_W-1){1'b0}}, 1'b1}) : x;
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add MUL / restoring signed DIV, fixed DATA_W+1 cycle latency
module mul_div_unit import riscv_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  md
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dsr_q, dsr_d;
    logic                neg_q, neg_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                stall;

    logic [DATA_W-1:0]   a_mag, b_mag, quo_raw, quo_fix;
    logic                a_sign, b_sign, q_sign_unused;
    logic [2*DATA_W-1:0] mul_sum;
    logic [DATA_W:0]     rem_trial, rem_diff;
    logic                q_bit;

    md_sign_abs #(.DATA_W(DATA_W)) u_abs_a (
        .x(md.in_A), .neg(md.in_A[DATA_W-1]), .y(a_mag), .sign(a_sign));
    md_sign_abs #(.DATA_W(DATA_W)) u_abs_b (
        .x(md.in_B), .neg(md.in_B[DATA_W-1]), .y(b_mag), .sign(b_sign));
    md_sign_abs #(.DATA_W(DATA_W)) u_neg_q (
        .x(quo_raw), .neg(neg_q), .y(quo_fix), .sign(q_sign_unused));

    // Datapath for one iteration; the dividend register shifts quotient bits in from the right.
    always_comb begin
        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        rem_trial = {rem_q, dvd_q[DATA_W-1]};
        rem_diff  = rem_trial - {1'b0, dsr_q};
        q_bit     = ~rem_diff[DATA_W];
        quo_raw   = {dvd_q[DATA_W-2:0], q_bit};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        stall    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                stall = md.valid;
                if (md.valid) begin
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{DATA_W{1'b0}}, md.in_A};
                    mplier_d = md.in_B;
                    rem_d    = '0;
                    dvd_d    = a_mag;
                    dsr_d    = b_mag;
                    neg_d    = a_sign ^ b_sign;
                    dz_d     = (md.in_B == '0);
                    ovf_d    = (md.in_A == MIN_NEG) && (md.in_B == ALL_ONES);
                    state_d  = (md.mode == MD_MODE_DIV) ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL: begin
                stall    = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = MD_OUT;
                    result_d = mul_sum[DATA_W-1:0];
                end
            end
            MD_DIV: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                rem_d = q_bit ? rem_diff[DATA_W-1:0] : rem_trial[DATA_W-1:0];
                dvd_d = quo_raw;
                if (cnt_q == CNT_LAST) begin
                    state_d  = MD_OUT;
                    result_d = dz_q ? ALL_ONES : (ovf_q ? MIN_NEG : quo_fix);
                end
            end
            MD_OUT: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign md.stall  = stall;
    assign md.done   = (state_q == MD_OUT);
    assign md.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_div_unit_if #(.DATA_W(32)) md ();
    mul_div_unit #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .md(md));

    int n_vec = 0;
    int n_err = 0;

    // Cycle k=0 is the request cycle; operands are scrambled after capture.
    task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                         input int n_cyc, input int hold_k,
                         output logic [31:0] res, output int done_k, output int stall_n,
                         output int done_n, output logic [31:0] res_end);
        res = 'x; done_k = -1; stall_n = 0; done_n = 0; res_end = 'x;
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            md.valid = (k <= hold_k);
            if (k == 0) begin
                md.mode = m; md.in_A = a; md.in_B = b;
            end else begin
                md.mode = ~m; md.in_A = $urandom; md.in_B = $urandom;
            end
            #1;
            if (md.stall) stall_n++;
            if (md.done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    res = md.result;
                end
            end
            res_end = md.result;
        end
        md.valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (md.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", md.done); end
        n_vec++; if (md.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", md.result); end
        n_vec++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_lo: got %b want 0", md.stall); end
        md.valid = 1'b1;
        #1;
        n_vec++; if (md.stall !== 1'b1) begin n_err++; $display("FAIL reset_stall_valid: got %b want 1", md.stall); end
        md.valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        logic [31:0] va [3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [3] = '{32'd6, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] ve [3] = '{32'd42, 32'h0000_0001, 32'h0000_0000};
        logic [31:0] res, res_end;
        int done_k, stall_n, done_n;
        for (int i = 0; i < 3; i++) begin
            do_op(MD_MODE_MUL, va[i], vb[i], 45, 0, res, done_k, stall_n, done_n, res_end);
            n_vec++; if (res !== ve[i]) begin n_err++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, ve[i]); end
            n_vec++; if (done_k !== 33) begin n_err++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, done_k); end
            n_vec++; if (stall_n !== 33) begin n_err++; $display("FAIL mul_stall_cycles[%0d]: got %0d want 33", i, stall_n); end
            n_vec++; if (done_n !== 1) begin n_err++; $display("FAIL mul_done_count[%0d]: got %0d want 1", i, done_n); end
            n_vec++; if (res_end !== ve[i]) begin n_err++; $display("FAIL mul_result_hold[%0d]: got %h want %h", i, res_end, ve[i]); end
        end
    endtask

    task automatic test_div;
        logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'd7, 32'd100, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] vb [6] = '{32'd2, 32'hFFFF_FFFE, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ve [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] res, res_end;
        int done_k, stall_n, done_n;
        for (int i = 0; i < 6; i++) begin
            do_op(MD_MODE_DIV, va[i], vb[i], 40, 0, res, done_k, stall_n, done_n, res_end);
            n_vec++; if (res !== ve[i]) begin n_err++; $display("FAIL div_result[%0d]: got %h want %h", i, res, ve[i]); end
            n_vec++; if (done_k !== 33) begin n_err++; $display("FAIL div_latency[%0d]: got %0d want 33", i, done_k); end
            n_vec++; if (done_n !== 1) begin n_err++; $display("FAIL div_done_count[%0d]: got %0d want 1", i, done_n); end
        end
    endtask

    task automatic test_valid_hold;
        logic [31:0] res, res_end;
        int done_k, stall_n, done_n;
        do_op(MD_MODE_MUL, 32'd9, 32'd9, 70, 33, res, done_k, stall_n, done_n, res_end);
        n_vec++; if (done_n !== 1) begin n_err++; $display("FAIL hold_done_count: got %0d want 1", done_n); end
        n_vec++; if (stall_n !== 33) begin n_err++; $display("FAIL hold_stall_cycles: got %0d want 33", stall_n); end
        n_vec++; if (res !== 32'd81) begin n_err++; $display("FAIL hold_result: got %h want %h", res, 32'd81); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res, res_end;
        int done_k, stall_n, done_n;
        do_op(MD_MODE_MUL, 32'd12, 32'd11, 34, 0, res, done_k, stall_n, done_n, res_end);
        n_vec++; if (res !== 32'd132) begin n_err++; $display("FAIL b2b_mul_result: got %h want %h", res, 32'd132); end
        n_vec++; if (done_k !== 33) begin n_err++; $display("FAIL b2b_mul_latency: got %0d want 33", done_k); end
        do_op(MD_MODE_DIV, 32'hFFFF_FF9C, 32'd7, 40, 0, res, done_k, stall_n, done_n, res_end);
        n_vec++; if (res !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL b2b_div_result: got %h want %h", res, 32'hFFFF_FFF2); end
        n_vec++; if (done_k !== 33) begin n_err++; $display("FAIL b2b_div_latency: got %0d want 33", done_k); end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] res, res_end;
        int done_k, stall_n, done_n;
        int late_done = 0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            md.valid = (k == 0);
            if (k == 0) begin
                md.mode = MD_MODE_DIV; md.in_A = 32'd100; md.in_B = 32'd7;
            end
            if (k == 9) begin
                #1;
                n_vec++; if (md.stall !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", md.stall); end
            end
            if (k == 10) begin
                rst_n = 1'b0;
                #1;
                n_vec++; if (dut.state_q !== MD_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want %0d", dut.state_q, MD_IDLE); end
                n_vec++; if (md.result !== 32'h0) begin n_err++; $display("FAIL rstmid_result: got %h want 0", md.result); end
                n_vec++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b want 0", md.stall); end
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (md.done) late_done++;
        end
        n_vec++; if (late_done !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", late_done); end
        do_op(MD_MODE_DIV, 32'd100, 32'd7, 40, 0, res, done_k, stall_n, done_n, res_end);
        n_vec++; if (res !== 32'd14) begin n_err++; $display("FAIL rstmid_fresh_result: got %h want %h", res, 32'd14); end
        n_vec++; if (done_k !== 33) begin n_err++; $display("FAIL rstmid_fresh_latency: got %0d want 33", done_k); end
    endtask

    initial begin
        rst_n    = 1'b0;
        md.valid = 1'b0;
        md.mode  = 1'b0;
        md.in_A  = '0;
        md.in_B  = '0;
        test_reset;
        test_mul;
        test_div;
        test_valid_hold;
        test_back_to_back;
        test_reset_mid_op;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
